// File: rtl/img_lb_pkg.sv
// Shared types and constants for the three-row image line buffer.
// The optional top-border replication is selected with LB_TOP_BORDER_REPLICATE_EN (see img_line_buff3x).
package img_lb_pkg;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        FILL     = 2'd1,
        RUN      = 2'd2
    } lb_state_t;

    localparam int PIX_WIDTH          = 8;
    localparam int DEFAULT_DATA_WIDTH = 64;
    localparam int PIX_PER_BEAT       = DEFAULT_DATA_WIDTH / PIX_WIDTH;
    localparam int DEFAULT_MAX_BEATS  = 256;

endpackage

// File: rtl/img_lb_ram.sv
// Simple dual-port, single-clock, read-first line memory with a registered read port.
module img_lb_ram #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Same-address read and write return the old contents (read-first).
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/img_line_buff3x.sv
// Three-row line buffer: emits rows n-2, n-1, n column-aligned with one cycle of latency.
// Define LB_TOP_BORDER_REPLICATE_EN to start output at input row 1 with row 0 replicated on top.
module img_line_buff3x
    import img_lb_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BEATS  = DEFAULT_MAX_BEATS,
    parameter int ADDR_WIDTH = $clog2(MAX_BEATS)
) (
    input  logic                  s_axis_aclk,
    input  logic                  s_axis_aresetn,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tlast,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    output logic                  m_axis_line_buff_0_tvalid,
    output logic                  m_axis_line_buff_1_tvalid,
    output logic                  m_axis_line_buff_2_tvalid,
    output logic                  m_axis_line_buff_0_tuser,
    output logic                  m_axis_line_buff_1_tuser,
    output logic                  m_axis_line_buff_2_tuser,
    output logic                  m_axis_line_buff_0_tlast,
    output logic                  m_axis_line_buff_1_tlast,
    output logic                  m_axis_line_buff_2_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_line_buff_0_tdata,
    output logic [DATA_WIDTH-1:0] m_axis_line_buff_1_tdata,
    output logic [DATA_WIDTH-1:0] m_axis_line_buff_2_tdata,
    output logic                  line_overflow
);

`ifdef LB_TOP_BORDER_REPLICATE_EN
    localparam logic [1:0] FILL_ROWS = 2'd1;
`else
    localparam logic [1:0] FILL_ROWS = 2'd2;
`endif

    lb_state_t             state_reg, state_next;
    logic [ADDR_WIDTH-1:0] col_cnt_reg, col_cnt_next;
    logic                  col_full_reg, col_full_next;
    logic [1:0]            row_cnt_reg, row_cnt_next;
    logic                  wr_sel_reg, wr_sel_next;
    logic                  first_out_reg, first_out_next;
    logic                  overflow_reg, overflow_next;
`ifdef LB_TOP_BORDER_REPLICATE_EN
    logic                  first_row_reg, first_row_next;
    logic                  rep_reg;
`endif

    logic                  out_valid_reg, out_user_reg, out_last_reg;
    logic [DATA_WIDTH-1:0] line2_reg;
    logic                  rd_sel_reg;
    logic                  primed_reg;

    logic                  sof, accept, produce, beyond, wr_en, cur_sel;
    logic [ADDR_WIDTH-1:0] beat_col;
    logic [1:0]            row_base;
    logic [DATA_WIDTH-1:0] rd_data [2];
    logic [DATA_WIDTH-1:0] line0_raw, line1_raw, line0_sel;

    assign sof      = s_axis_tvalid & s_axis_tuser;
    assign accept   = s_axis_tvalid & (sof | (state_reg != WAIT_SOF));
    assign produce  = accept & ~sof & (state_reg == RUN);
    assign beat_col = sof ? '0 : col_cnt_reg;
    assign beyond   = ~sof & col_full_reg;
    assign wr_en    = accept & ~beyond;
    assign cur_sel  = sof ? 1'b0 : wr_sel_reg;
    assign row_base = sof ? 2'd0 : row_cnt_reg;

    // The two memories swap roles every line: the one written this row holds row n-2
    // (read out before being overwritten), the other holds row n-1. This is the
    // memB <= memA shift without a second read-modify-write.
    for (genvar gi = 0; gi < 2; gi++) begin : g_line_mem
        img_lb_ram #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (MAX_BEATS),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_ram (
            .clk  (s_axis_aclk),
            .we   (wr_en & (cur_sel == 1'(gi))),
            .waddr(beat_col),
            .wdata(s_axis_tdata),
            .re   (produce),
            .raddr(beat_col),
            .rdata(rd_data[gi])
        );
    end

    always_comb begin
        state_next     = state_reg;
        col_cnt_next   = col_cnt_reg;
        col_full_next  = col_full_reg;
        row_cnt_next   = row_cnt_reg;
        wr_sel_next    = wr_sel_reg;
        first_out_next = first_out_reg;
        overflow_next  = overflow_reg;
`ifdef LB_TOP_BORDER_REPLICATE_EN
        first_row_next = first_row_reg;
`endif
        if (accept) begin
            wr_sel_next = cur_sel;
            if (s_axis_tlast) begin
                col_cnt_next  = '0;
                col_full_next = 1'b0;
                wr_sel_next   = ~cur_sel;
            end else if (beat_col == ADDR_WIDTH'(MAX_BEATS - 1)) begin
                col_cnt_next  = beat_col;
                col_full_next = 1'b1;
            end else begin
                col_cnt_next  = beat_col + 1'b1;
                col_full_next = 1'b0;
            end

            if (sof) begin
                overflow_next = 1'b0;
                row_cnt_next  = 2'd0;
                state_next    = FILL;
            end else if (beyond) begin
                overflow_next = 1'b1;
            end

            if (s_axis_tlast && (sof || state_reg == FILL)) begin
                row_cnt_next = row_base + 2'd1;
                if (row_base + 2'd1 == FILL_ROWS) begin
                    state_next     = RUN;
                    first_out_next = 1'b1;
`ifdef LB_TOP_BORDER_REPLICATE_EN
                    first_row_next = 1'b1;
`endif
                end
            end

            if (produce) begin
                first_out_next = 1'b0;
`ifdef LB_TOP_BORDER_REPLICATE_EN
                if (s_axis_tlast) begin
                    first_row_next = 1'b0;
                end
`endif
            end
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_reg     <= WAIT_SOF;
            col_cnt_reg   <= '0;
            col_full_reg  <= 1'b0;
            row_cnt_reg   <= 2'd0;
            wr_sel_reg    <= 1'b0;
            first_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
`ifdef LB_TOP_BORDER_REPLICATE_EN
            first_row_reg <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            col_cnt_reg   <= col_cnt_next;
            col_full_reg  <= col_full_next;
            row_cnt_reg   <= row_cnt_next;
            wr_sel_reg    <= wr_sel_next;
            first_out_reg <= first_out_next;
            overflow_reg  <= overflow_next;
`ifdef LB_TOP_BORDER_REPLICATE_EN
            first_row_reg <= first_row_next;
`endif
        end
    end

    // Side-band and bottom row are registered only on output beats so they hold in gaps.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            out_valid_reg <= 1'b0;
            out_user_reg  <= 1'b0;
            out_last_reg  <= 1'b0;
            line2_reg     <= '0;
            rd_sel_reg    <= 1'b0;
            primed_reg    <= 1'b0;
`ifdef LB_TOP_BORDER_REPLICATE_EN
            rep_reg       <= 1'b0;
`endif
        end else begin
            out_valid_reg <= produce;
            if (produce) begin
                out_user_reg <= first_out_reg;
                out_last_reg <= s_axis_tlast;
                line2_reg    <= s_axis_tdata;
                rd_sel_reg   <= cur_sel;
                primed_reg   <= 1'b1;
`ifdef LB_TOP_BORDER_REPLICATE_EN
                rep_reg      <= first_row_reg;
`endif
            end
        end
    end

    assign line0_raw = rd_data[rd_sel_reg];
    assign line1_raw = rd_data[~rd_sel_reg];
`ifdef LB_TOP_BORDER_REPLICATE_EN
    assign line0_sel = rep_reg ? line1_raw : line0_raw;
`else
    assign line0_sel = line0_raw;
`endif

    // RAM read registers are not reset, so mask them until the first output beat.
    assign m_axis_line_buff_0_tdata  = primed_reg ? line0_sel : '0;
    assign m_axis_line_buff_1_tdata  = primed_reg ? line1_raw : '0;
    assign m_axis_line_buff_2_tdata  = line2_reg;

    assign m_axis_line_buff_0_tvalid = out_valid_reg;
    assign m_axis_line_buff_1_tvalid = out_valid_reg;
    assign m_axis_line_buff_2_tvalid = out_valid_reg;
    assign m_axis_line_buff_0_tuser  = out_user_reg;
    assign m_axis_line_buff_1_tuser  = out_user_reg;
    assign m_axis_line_buff_2_tuser  = out_user_reg;
    assign m_axis_line_buff_0_tlast  = out_last_reg;
    assign m_axis_line_buff_1_tlast  = out_last_reg;
    assign m_axis_line_buff_2_tlast  = out_last_reg;
    assign line_overflow             = overflow_reg;

endmodule

// File: tb/tb_img_line_buff3x.sv
// Randomized directed bench for img_line_buff3x against a row-queue reference model.
module tb_img_line_buff3x;

    localparam int DW   = 64;
    localparam int MAXB = 256;
`ifdef LB_TOP_BORDER_REPLICATE_EN
    localparam int FILL_ROWS = 1;
    localparam bit REP       = 1'b1;
`else
    localparam int FILL_ROWS = 2;
    localparam bit REP       = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tvalid, tuser, tlast;
    logic [DW-1:0] tdata;
    logic          v0, v1, v2, u0, u1, u2, l0, l1, l2, ovf;
    logic [DW-1:0] d0, d1, d2;

    always #5 clk = ~clk;

    img_line_buff3x #(.DATA_WIDTH(DW), .MAX_BEATS(MAXB)) dut (
        .s_axis_aclk              (clk),
        .s_axis_aresetn           (rst_n),
        .s_axis_tvalid            (tvalid),
        .s_axis_tuser             (tuser),
        .s_axis_tlast             (tlast),
        .s_axis_tdata             (tdata),
        .m_axis_line_buff_0_tvalid(v0),
        .m_axis_line_buff_1_tvalid(v1),
        .m_axis_line_buff_2_tvalid(v2),
        .m_axis_line_buff_0_tuser (u0),
        .m_axis_line_buff_1_tuser (u1),
        .m_axis_line_buff_2_tuser (u2),
        .m_axis_line_buff_0_tlast (l0),
        .m_axis_line_buff_1_tlast (l1),
        .m_axis_line_buff_2_tlast (l2),
        .m_axis_line_buff_0_tdata (d0),
        .m_axis_line_buff_1_tdata (d1),
        .m_axis_line_buff_2_tdata (d2),
        .line_overflow            (ovf)
    );

    int n_vec = 0;
    int n_bad = 0;
    int out_cnt = 0;

    // Reference model: complete previous rows kept as queues.
    logic [DW-1:0] cur[$], p1[$], p2[$];
    int  m_state = 0;   // 0 waiting for SOF, 1 filling, 2 running
    int  m_rows  = 0;
    int  m_col   = 0;
    bit  m_first = 0, m_rep = 0, m_ovf = 0;
    logic          h_u = 0, h_l = 0;
    logic [DW-1:0] h_d0 = 0, h_d1 = 0, h_d2 = 0;
    bit            h_k0 = 1, h_k1 = 1;

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic chk64(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic finish_row();
        p2 = p1;
        p1 = cur;
        cur.delete();
        m_col = 0;
        if (m_state == 1) begin
            m_rows++;
            if (m_rows == FILL_ROWS) begin
                m_state = 2;
                m_first = 1;
                m_rep   = 1;
            end
        end
    endtask

    task automatic model_reset();
        cur.delete(); p1.delete(); p2.delete();
        m_state = 0; m_rows = 0; m_col = 0;
        m_first = 0; m_rep = 0; m_ovf = 0;
        h_u = 0; h_l = 0; h_d0 = 0; h_d1 = 0; h_d2 = 0; h_k0 = 1; h_k1 = 1;
    endtask

    task automatic step(input bit v, input bit u, input bit l, input logic [DW-1:0] d);
        bit ev, eu, el, k0, k1;
        logic [DW-1:0] e0, e1;
        tvalid = v; tuser = u; tlast = l; tdata = d;
        @(posedge clk);
        #1;
        ev = 0; eu = 0; el = 0; k0 = 0; k1 = 0; e0 = '0; e1 = '0;
        if (v && u) begin
            cur.delete(); p1.delete(); p2.delete();
            m_state = 1; m_rows = 0; m_ovf = 0;
            cur.push_back(d);
            m_col = 1;
            if (l) finish_row();
        end else if (v && m_state != 0) begin
            if (m_state == 2) begin
                ev = 1; eu = m_first; m_first = 0; el = l;
                if (m_col < MAXB && m_col < p1.size()) begin k1 = 1; e1 = p1[m_col]; end
                if (REP && m_rep) begin
                    k0 = k1; e0 = e1;
                end else if (m_col < MAXB && m_col < p2.size()) begin
                    k0 = 1; e0 = p2[m_col];
                end
                if (l) m_rep = 0;
            end
            if (m_col >= MAXB) m_ovf = 1;
            else cur.push_back(d);
            m_col++;
            if (l) finish_row();
        end

        chk1("tvalid0", v0, ev);
        chk1("tvalid1", v1, ev);
        chk1("tvalid2", v2, ev);
        chk1("overflow", ovf, m_ovf);
        if (ev) begin
            out_cnt++;
            chk1("tuser0", u0, eu); chk1("tuser1", u1, eu); chk1("tuser2", u2, eu);
            chk1("tlast0", l0, el); chk1("tlast1", l1, el); chk1("tlast2", l2, el);
            chk64("line2", d2, d);
            if (k1) chk64("line1", d1, e1);
            if (k0) chk64("line0", d0, e0);
            h_u = eu; h_l = el; h_d2 = d; h_d1 = e1; h_d0 = e0; h_k1 = k1; h_k0 = k0;
        end else begin
            chk1("tuser_hold", u0, h_u);
            chk1("tlast_hold", l0, h_l);
            chk64("line2_hold", d2, h_d2);
            if (h_k1) chk64("line1_hold", d1, h_d1);
            if (h_k0) chk64("line0_hold", d0, h_d0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), 1'($urandom), {$urandom, $urandom});
    endtask

    // gap: 0 none, 1 toggle valid every cycle, 2 random gaps; stop_after < 0 sends the full frame.
    task automatic send_frame(input int rows, input int cols, input int gap, input int stop_after);
        int n;
        n = 0;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                if (stop_after >= 0 && n >= stop_after) return;
                step(1'b1, (r == 0 && c == 0), (c == cols - 1), {$urandom, 16'(r), 16'(c)});
                n++;
                if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0)) idle(1);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; tvalid = 0; tuser = 0; tlast = 0; tdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_tvalid", v0, 1'b0);
        chk1("rst_tuser", u0, 1'b0);
        chk1("rst_tlast", l0, 1'b0);
        chk64("rst_line0", d0, '0);
        chk64("rst_line1", d1, '0);
        chk64("rst_line2", d2, '0);
        chk1("rst_overflow", ovf, 1'b0);
        rst_n = 1'b1;

        // Beats before any SOF are discarded.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, (i == 2), {$urandom, $urandom});

        out_cnt = 0;
        send_frame(5, 4, 0, -1);
        chk64("rows_out_plain", 64'(out_cnt), 64'((5 - FILL_ROWS) * 4));

        out_cnt = 0;
        send_frame(5, 4, 1, -1);
        chk64("rows_out_toggle", 64'(out_cnt), 64'((5 - FILL_ROWS) * 4));

        // Asynchronous reset in the middle of row 3.
        send_frame(5, 4, 0, 3 * 4 + 2);
        #2 rst_n = 1'b0;
        #1;
        chk1("midrst_tvalid", v0, 1'b0);
        chk64("midrst_line0", d0, '0);
        chk64("midrst_line2", d2, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, (i == 3), {$urandom, $urandom});
        out_cnt = 0;
        send_frame(3, 4, 0, -1);
        chk64("rows_out_after_rst", 64'(out_cnt), 64'((3 - FILL_ROWS) * 4));

        // SOF injected at row 2 col 1 of a running frame.
        send_frame(5, 4, 0, 2 * 4 + 1);
        out_cnt = 0;
        send_frame(4, 4, 2, -1);
        chk64("rows_out_resync", 64'(out_cnt), 64'((4 - FILL_ROWS) * 4));

        // Overlong first line, then normal rows; next SOF clears the sticky flag.
        for (int c = 0; c < MAXB + 2; c++)
            step(1'b1, (c == 0), (c == MAXB + 1), {$urandom, 16'd0, 16'(c)});
        for (int r = 1; r < 4; r++)
            for (int c = 0; c < 4; c++)
                step(1'b1, 1'b0, (c == 3), {$urandom, 16'(r), 16'(c)});
        chk1("overflow_sticky", ovf, 1'b1);
        send_frame(3, 4, 0, -1);
        chk1("overflow_cleared", ovf, 1'b0);

        // One-beat lines: tuser and tlast on the same beat.
        send_frame(4, 1, 0, -1);

        for (int f = 0; f < 4; f++)
            send_frame($urandom_range(3, 6), $urandom_range(1, 6), 2, -1);

        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/img_line_buff3x.md
Name: img_line_buff3x

Overview:
- Producer side of the three-row line-buffer stream interface consumed by the gradient/3x3 kernel blocks.
- Accepts one valid-only AXI-Stream video input carrying N packed pixels per beat.
- Stores the two previous lines and emits three column-aligned row streams per beat: line_buff_0 = row n-2 (top), line_buff_1 = row n-1 (centre), line_buff_2 = row n (bottom).
- Sits directly between the video source / DMA and the kernel block.

Parameters:
- DATA_WIDTH, 64, beat width in bits (8 pixels x 8 bits).
- MAX_BEATS, 256, maximum beats per line (2048 px at 8 px/beat); sets line memory depth.
- ADDR_WIDTH, $clog2(MAX_BEATS), column counter and memory address width.

Ports:
- s_axis_aclk  in  1  pixel clock; all logic on rising edge.
- s_axis_aresetn  in  1  reset, asynchronous assert, active-low.
- s_axis_tvalid  in  1  input beat valid; no backpressure.
- s_axis_tuser  in  1  start of frame, on first beat of row 0.
- s_axis_tlast  in  1  end of line.
- s_axis_tdata  in  DATA_WIDTH  packed pixels.
- m_axis_line_buff_{0,1,2}_tvalid  out  1 each  output beat valid; all three identical.
- m_axis_line_buff_{0,1,2}_tuser  out  1 each  SOF of output frame; all three identical.
- m_axis_line_buff_{0,1,2}_tlast  out  1 each  end of output line; all three identical.
- m_axis_line_buff_0_tdata  out  DATA_WIDTH  row n-2.
- m_axis_line_buff_1_tdata  out  DATA_WIDTH  row n-1.
- m_axis_line_buff_2_tdata  out  DATA_WIDTH  row n.
- line_overflow  out  1  sticky: a line exceeded MAX_BEATS; cleared on accepted tuser.

Behaviour:
- Reset (async, s_axis_aresetn=0):
  - All outputs 0.
  - col_cnt=0, row_cnt=0, state=WAIT_SOF.
  - Line memories not reset.
- State machine:
  - WAIT_SOF: discards input until a beat with tvalid&tuser, then -> FILL. That beat is processed as row 0, col 0.
  - FILL: row_cnt<2; beats are written but no output is produced. On tlast, row_cnt++; when row_cnt reaches 2 -> RUN.
  - RUN: every accepted beat produces one output beat.
- Beat accepted = tvalid=1 and state!=WAIT_SOF, or the SOF beat itself.
- Per accepted beat, at address col_cnt:
  - Read memA (row n-1) and memB (row n-2) with read-before-write.
  - Write memB <= old memA, then memA <= s_axis_tdata.
- Latency: exactly 1 cycle, input beat to registered output.
  - In RUN: out_tvalid=1; line_buff_2_tdata = delayed input; line_buff_1_tdata = old memA; line_buff_0_tdata = old memB.
  - out_tlast = delayed input tlast.
  - out_tuser = 1 on the first output beat after entering RUN, i.e. input row 2, col 0.
- tvalid=0: out_tvalid=0 next cycle; tdata/tuser/tlast outputs hold their last values; counters hold.
- tlast: col_cnt -> 0.
- col_cnt saturation: col_cnt saturates at MAX_BEATS-1. Beats beyond it are not written, line_overflow is set, and output data for those beats is don't-care (tvalid still follows the input).
- tuser mid-frame (any state): resynchronise; that beat becomes row 0 col 0, row_cnt=0, -> FILL, and its output (if any) is suppressed.
- tuser and tlast on the same beat: treated as a one-beat row 0; row_cnt=1.
- Short line after a longer line: unread tail memory is stale; not an error.
- Frame end: the last input row is never centred. Output row count = input rows - 2.

Optional Feature:
- Macro LB_TOP_BORDER_REPLICATE_EN.
- Defined:
  - FILL ends after row_cnt reaches 1, so output starts at input row 1 with out_tuser on row 1 col 0.
  - For that first output row only, line_buff_0_tdata = line_buff_1_tdata (row 0 replicated).
  - Output rows = input rows - 1.
- Undefined: behaviour exactly as above.

Decomposition:
- Package img_lb_pkg:
  - state enum (WAIT_SOF, FILL, RUN).
  - PIX_WIDTH=8, PIX_PER_BEAT=DATA_WIDTH/PIX_WIDTH.
  - Default MAX_BEATS.
- Sub-module img_lb_ram: simple dual-port single-clock read-first RAM, DATA_WIDTH x MAX_BEATS, instantiated twice (memA, memB).

Test Plan:
- Frame 4 beats x 5 rows, beat data = {row,col} pattern -> 3 output rows; row-2 col-0 out has line0={0,0}, line1={1,0}, line2={2,0}, tuser=1; tlast on col 3; latency 1 cycle.
- Same frame with tvalid toggled 1/0 every cycle -> identical output sequence, out_tvalid gaps mirror input 1 cycle later, data held during gaps.
- Reset asserted mid-row 3, released, then frame with 3 rows -> no output before the new tuser; then one output row using only the new frame's data.
- tuser injected at row 2 col 1 of a running frame -> output stops; restart fill; first output at new row 2 with tuser=1.
- Line of MAX_BEATS+2 beats -> line_overflow=1 after beat MAX_BEATS; cleared by next tuser; col 0 of following rows correct.
- LB_TOP_BORDER_REPLICATE_EN defined, 4x3 frame -> 2 output rows; first row line0==line1=row 0 data, tuser at input row 1 col 0.
